feature_crop: RTL and testbench

FEATURE_CROP -- requirements
Module: feature_crop

---
 rtl/cnn_pkg.sv | 19 +
 rtl/raster_cnt.sv | 55 +++++
 rtl/feature_crop.sv | 103 ++++++++++
 tb/tb_feature_crop.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types, default map sizes and small helpers for the CNN feature-map datapath.
package cnn_pkg;

  typedef logic [31:0] word_t;

  localparam int unsigned PAD_IN_SIZE = 9;
  localparam int unsigned MAP_SIZE    = 5;

  // Counter width for a 0..size-1 range, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

  function automatic logic in_range(input int unsigned v, input int unsigned lo,
                                    input int unsigned len);
    return (v >= lo) && (v < lo + len);
  endfunction

endpackage

// File: rtl/raster_cnt.sv
// Row/column position counter for a SIZE x SIZE raster-order stream.
// wrap flags the advance that returns the counter to the origin (frame end or resync).
module raster_cnt
  import cnn_pkg::*;
#(
  parameter int unsigned SIZE = PAD_IN_SIZE,
  parameter int unsigned CW   = cnt_width(SIZE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          advance,
  input  logic          resync,
  output logic [CW-1:0] row,
  output logic [CW-1:0] col,
  output logic          wrap,
  output logic          final_pos
);

  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;

  assign row       = row_q;
  assign col       = col_q;
  assign final_pos = (row_q == LAST) && (col_q == LAST);
  assign wrap      = advance && (resync || final_pos);

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (wrap) begin
      row_d = '0;
      col_d = '0;
    end else if (advance) begin
      if (col_q == LAST) begin
        col_d = '0;
        row_d = row_q + CW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/feature_crop.sv
// Crops an OUT_SIZE x OUT_SIZE window out of a raster-order padded feature map stream.
// Kept words go through one output register that sustains a word per cycle.
module feature_crop
  import cnn_pkg::*;
#(
  parameter int unsigned IN_SIZE  = PAD_IN_SIZE,
  parameter int unsigned OUT_SIZE = MAP_SIZE,
  parameter int unsigned ROW_OFF  = 0,
  parameter int unsigned COL_OFF  = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  input  logic        s_last,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        m_last,
  output logic        frame_done,
  output logic        err
);

  localparam int unsigned   CW       = cnt_width(IN_SIZE);
  localparam logic [CW-1:0] ROW_LAST = CW'(ROW_OFF + OUT_SIZE - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COL_OFF + OUT_SIZE - 1);

  if ((OUT_SIZE < 1) || (ROW_OFF + OUT_SIZE > IN_SIZE) || (COL_OFF + OUT_SIZE > IN_SIZE))
  begin : g_window_check
    $error("feature_crop: crop window does not fit inside the input map");
  end

  logic [CW-1:0] row, col;
  logic          final_pos, frame_wrap;
  logic          accept, keep, last_kept;

  word_t m_data_q, m_data_d;
  logic  m_valid_q, m_valid_d;
  logic  m_last_q, m_last_d;
  logic  frame_done_q;
  logic  err_q, err_d;

  // Ready whenever the output register is empty or draining this cycle.
  assign s_ready = reset && (!m_valid_q || m_ready);
  assign accept  = s_valid && s_ready;

  raster_cnt #(
    .SIZE (IN_SIZE),
    .CW   (CW)
  ) u_raster_cnt (
    .clk       (clk),
    .reset     (reset),
    .advance   (accept),
    .resync    (s_last),
    .row       (row),
    .col       (col),
    .wrap      (frame_wrap),
    .final_pos (final_pos)
  );

  assign keep = accept && in_range(32'(row), ROW_OFF, OUT_SIZE)
                       && in_range(32'(col), COL_OFF, OUT_SIZE);
  assign last_kept = (row == ROW_LAST) && (col == COL_LAST);

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    if (keep) begin
      m_valid_d = 1'b1;
      m_data_d  = s_data;
      m_last_d  = last_kept;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end
    // s_last disagreeing with the counted frame end in either direction is a length error.
    err_d = err_q || (accept && (s_last != final_pos));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_last_q     <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_last_q     <= m_last_d;
      frame_done_q <= frame_wrap;
      err_q        <= err_d;
    end
  end

  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_last     = m_last_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_feature_crop.sv
// Bench for feature_crop: default crop, offset crop and 5x5 passthrough instances.
module tb_feature_crop;

  localparam int NDUT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                       reset;
  logic [NDUT-1:0]            s_valid, s_ready, s_last;
  logic [NDUT-1:0][31:0]      s_data;
  logic [NDUT-1:0]            m_valid, m_ready, m_last, frame_done, err;
  logic [NDUT-1:0][31:0]      m_data;
  logic [NDUT-1:0]            man_ready, rnd_mode, rnd_bit;

  feature_crop #(.IN_SIZE(9), .OUT_SIZE(5), .ROW_OFF(0), .COL_OFF(0)) u_dut_def (
    .clk(clk), .reset(reset), .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_data(s_data[0]),
    .s_last(s_last[0]), .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_data(m_data[0]),
    .m_last(m_last[0]), .frame_done(frame_done[0]), .err(err[0])
  );

  feature_crop #(.IN_SIZE(9), .OUT_SIZE(5), .ROW_OFF(2), .COL_OFF(3)) u_dut_off (
    .clk(clk), .reset(reset), .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_data(s_data[1]),
    .s_last(s_last[1]), .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_data(m_data[1]),
    .m_last(m_last[1]), .frame_done(frame_done[1]), .err(err[1])
  );

  feature_crop #(.IN_SIZE(5), .OUT_SIZE(5), .ROW_OFF(0), .COL_OFF(0)) u_dut_pass (
    .clk(clk), .reset(reset), .s_valid(s_valid[2]), .s_ready(s_ready[2]), .s_data(s_data[2]),
    .s_last(s_last[2]), .m_valid(m_valid[2]), .m_ready(m_ready[2]), .m_data(m_data[2]),
    .m_last(m_last[2]), .frame_done(frame_done[2]), .err(err[2])
  );

  always_comb begin
    for (int d = 0; d < NDUT; d++) m_ready[d] = rnd_mode[d] ? rnd_bit[d] : man_ready[d];
  end

  initial begin
    rnd_bit = '1;
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < NDUT; d++) rnd_bit[d] = 1'($urandom_range(0, 1));
    end
  end

  // Transfer log and per-DUT event counters, all cleared by reset.
  int          got_dut[$];
  logic [31:0] got_data[$];
  logic        got_last[$];
  int          fd_cnt[NDUT];
  int          stall_err[NDUT];
  logic [NDUT-1:0]       prev_stall;
  logic [NDUT-1:0][31:0] prev_data;

  always @(negedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      if (!reset) begin
        fd_cnt[d]    <= 0;
        stall_err[d] <= 0;
      end else begin
        if (prev_stall[d] && (!m_valid[d] || m_data[d] != prev_data[d]))
          stall_err[d] <= stall_err[d] + 1;
        if (m_valid[d] && m_ready[d]) begin
          got_dut.push_back(d);
          got_data.push_back(m_data[d]);
          got_last.push_back(m_last[d]);
        end
        if (frame_done[d]) fd_cnt[d] <= fd_cnt[d] + 1;
      end
      prev_stall[d] <= reset && m_valid[d] && !m_ready[d];
      prev_data[d]  <= m_data[d];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  logic [31:0] exp_data[$];
  logic        exp_last[$];

  task automatic build_exp(input int in_size, input int out_size, input int ro, input int co,
                           input int n);
    exp_data.delete();
    exp_last.delete();
    for (int w = 0; w < n; w++) begin
      int r;
      int c;
      r = (w / in_size) % in_size;
      c = w % in_size;
      if (r >= ro && r < ro + out_size && c >= co && c < co + out_size) begin
        exp_data.push_back(32'(w));
        exp_last.push_back(r == ro + out_size - 1 && c == co + out_size - 1);
      end
    end
  endtask

  task automatic compare_from(input int d, input int base, input string name);
    int k;
    k = 0;
    for (int i = base; i < got_data.size(); i++) begin
      if (got_dut[i] == d) begin
        if (k < exp_data.size()) begin
          check($sformatf("%s_data%0d", name, k), got_data[i], exp_data[k]);
          check($sformatf("%s_last%0d", name, k), got_last[i], exp_last[k]);
        end
        k++;
      end
    end
    check({name, "_count"}, k, exp_data.size());
  endtask

  task automatic send_frame(input int d, input int n, input int last_at, input bit gaps,
                            output int cycles);
    cycles = 0;
    for (int w = 0; w < n; w++) begin
      bit acc;
      int waited;
      acc = 1'b0;
      waited = 0;
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          s_valid[d] = 1'b0;
          @(posedge clk);
          #1;
          cycles++;
        end
      end
      s_valid[d] = 1'b1;
      s_data[d]  = 32'(w);
      s_last[d]  = (w == last_at);
      while (!acc && waited < 200) begin
        @(negedge clk);
        acc = s_ready[d];
        @(posedge clk);
        #1;
        waited++;
        cycles++;
      end
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: dut %0d word %0d got no s_ready, required within 200", d, w);
        break;
      end
    end
    s_valid[d] = 1'b0;
    s_last[d]  = 1'b0;
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    rnd_mode[d]  = 1'b0;
    man_ready[d] = 1'b1;
    while (m_valid[d] && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (m_valid[d]) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: dut %0d m_valid still 1, required 0", d);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  typedef struct {
    logic        sv;
    logic [31:0] sd;
    logic        mr;
    logic        exp_sr;
    logic        exp_mv;
    logic [31:0] exp_md;
    logic        exp_ml;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int cyc;
    int fd0;

    // Register-slice handshake on the 5x5 passthrough instance; outputs are after the edge.
    tbl[0] = '{1'b1, 32'hA000_0000, 1'b0, 1'b1, 1'b1, 32'hA000_0000, 1'b0};
    tbl[1] = '{1'b1, 32'hA000_0001, 1'b0, 1'b0, 1'b1, 32'hA000_0000, 1'b0};
    tbl[2] = '{1'b1, 32'hA000_0001, 1'b1, 1'b1, 1'b1, 32'hA000_0001, 1'b0};
    tbl[3] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'hA000_0001, 1'b0};
    tbl[4] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b0};
    tbl[5] = '{1'b1, 32'hA000_0002, 1'b0, 1'b1, 1'b1, 32'hA000_0002, 1'b0};
    tbl[6] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b0};

    reset     = 1'b0;
    s_valid   = '0;
    s_data    = '0;
    s_last    = '0;
    man_ready = '1;
    rnd_mode  = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("rst%0d_s_ready", d), s_ready[d], 0);
      check($sformatf("rst%0d_m_valid", d), m_valid[d], 0);
      check($sformatf("rst%0d_m_data", d), m_data[d], 0);
      check($sformatf("rst%0d_m_last", d), m_last[d], 0);
      check($sformatf("rst%0d_frame_done", d), frame_done[d], 0);
      check($sformatf("rst%0d_err", d), err[d], 0);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;

    for (int i = 0; i < 7; i++) begin
      s_valid[2]   = tbl[i].sv;
      s_data[2]    = tbl[i].sd;
      s_last[2]    = 1'b0;
      man_ready[2] = tbl[i].mr;
      @(negedge clk);
      check($sformatf("tbl%0d_s_ready", i), s_ready[2], tbl[i].exp_sr);
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_m_valid", i), m_valid[2], tbl[i].exp_mv);
      if (tbl[i].exp_mv) begin
        check($sformatf("tbl%0d_m_data", i), m_data[2], tbl[i].exp_md);
        check($sformatf("tbl%0d_m_last", i), m_last[2], tbl[i].exp_ml);
      end
    end
    s_valid[2]   = 1'b0;
    man_ready[2] = 1'b1;
    pulse_reset();

    // Default crop, always ready.
    base = got_data.size();
    fd0  = fd_cnt[0];
    build_exp(9, 5, 0, 0, 81);
    send_frame(0, 81, 80, 1'b0, cyc);
    drain(0);
    compare_from(0, base, "def");
    check("def_frame_done", fd_cnt[0] - fd0, 1);
    check("def_err", err[0], 0);

    // Offset crop: 21 first, 61 last.
    base = got_data.size();
    fd0  = fd_cnt[1];
    build_exp(9, 5, 2, 3, 81);
    send_frame(1, 81, 80, 1'b0, cyc);
    drain(1);
    compare_from(1, base, "off");
    check("off_frame_done", fd_cnt[1] - fd0, 1);
    check("off_err", err[1], 0);

    // Missing s_last on the final word: error, counters wrap normally.
    base = got_data.size();
    fd0  = fd_cnt[1];
    send_frame(1, 81, -1, 1'b0, cyc);
    drain(1);
    compare_from(1, base, "late");
    check("late_err", err[1], 1);
    check("late_frame_done", fd_cnt[1] - fd0, 1);
    base = got_data.size();
    send_frame(1, 81, 80, 1'b0, cyc);
    drain(1);
    compare_from(1, base, "late_next");

    // Random backpressure and input gaps.
    base = got_data.size();
    fd0  = fd_cnt[0];
    build_exp(9, 5, 0, 0, 81);
    rnd_mode[0] = 1'b1;
    send_frame(0, 81, 80, 1'b1, cyc);
    drain(0);
    compare_from(0, base, "rnd");
    check("rnd_stall_stable", stall_err[0], 0);
    check("rnd_frame_done", fd_cnt[0] - fd0, 1);

    // Passthrough at full rate.
    base = got_data.size();
    fd0  = fd_cnt[2];
    build_exp(5, 5, 0, 0, 25);
    send_frame(2, 25, 24, 1'b0, cyc);
    check("pass_cycles", cyc, 25);
    drain(2);
    compare_from(2, base, "pass");
    check("pass_frame_done", fd_cnt[2] - fd0, 1);

    // Early s_last on word 40, then a clean frame.
    base = got_data.size();
    fd0  = fd_cnt[0];
    build_exp(9, 5, 0, 0, 41);
    send_frame(0, 41, 40, 1'b0, cyc);
    drain(0);
    compare_from(0, base, "early");
    check("early_err", err[0], 1);
    check("early_frame_done", fd_cnt[0] - fd0, 1);
    base = got_data.size();
    build_exp(9, 5, 0, 0, 81);
    send_frame(0, 81, 80, 1'b0, cyc);
    drain(0);
    compare_from(0, base, "early_next");
    check("early_err_sticky", err[0], 1);

    // Reset right after word 30 drops the pending word and clears err.
    send_frame(0, 31, -1, 1'b0, cyc);
    check("mid_pending", m_valid[0], 1);
    pulse_reset();
    check("mid_m_valid", m_valid[0], 0);
    check("mid_err", err[0], 0);
    base = got_data.size();
    fd0  = fd_cnt[0];
    build_exp(9, 5, 0, 0, 81);
    send_frame(0, 81, 80, 1'b0, cyc);
    drain(0);
    compare_from(0, base, "restart");
    check("restart_frame_done", fd_cnt[0] - fd0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
